mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the fetch stage (I-port) and the MEM stage (D-port) of the pipelined core.
- Sequences each access through a registered request/ready handshake and returns the read data to the winning port with a one-cycle valid pulse.
- D-port has priority: it belongs to the older instruction. A streak limiter keeps fetch from starving.
- The pipeline derives its stalls as req & ~valid per port.

Parameters:
MAX_D_STREAK, 4, consecutive D grants allowed while an I request is pending before I is forced (must be >= 1)
TIMEOUT_CYCLES, 64, memory-wait limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  reset, asynchronous, active-low
i_iReq  in  1  fetch request, held until o_iValid
i_iAddr  in  32  fetch address
o_iData  out  32  fetched instruction
o_iValid  out  1  one-cycle pulse, o_iData valid
i_dReq  in  1  data request, held until o_dValid
i_dWrite  in  1  1 = store, 0 = load
i_dAddr  in  32  data address
i_dWdata  in  32  store data
i_dFunct3  in  3  access size/sign, passed to memory
o_dRdata  out  32  load data
o_dValid  out  1  one-cycle pulse, D access complete
o_mReq  out  1  memory request, held until i_mReady
o_mWrite  out  1  memory write enable
o_mAddr  out  32  memory address
o_mWdata  out  32  memory write data
o_mFunct3  out  3  memory access size; 3'b010 for fetches
i_mReady  in  1  memory done; i_mRdata valid this cycle
i_mRdata  in  32  memory read data
o_busy  out  1  high in BUSY and DONE
o_err  out  1  timeout pulse (see Optional Feature)

Behaviour:
- Reset is asynchronous; i_reset_n low forces all of the following immediately, including mid-transaction:
  - state = IDLE, streak = 0
  - all outputs 0, except o_iData = 32'h00000013
  - a memory access in flight is abandoned; the memory side must tolerate a dropped o_mReq.
- States are IDLE, BUSY and DONE.
- IDLE, grant decision:
  - Grant D if i_dReq and (~i_iReq or streak < MAX_D_STREAK).
  - Otherwise grant I if i_iReq.
  - Otherwise stay in IDLE.
  - If both requests are high and streak == MAX_D_STREAK, I wins.
- On a grant:
  - Register owner, address, write, wdata and funct3 into o_m* (fetch: write = 0, funct3 = 3'b010).
  - Go to BUSY.
- Streak counter:
  - D grant with i_iReq high: streak += 1, saturating.
  - D grant with i_iReq low: streak = 0.
  - I grant: streak = 0.
- BUSY:
  - o_mReq = 1; o_m* are held stable.
  - On i_mReady: capture i_mRdata into o_iData or o_dRdata (owner only; stores leave o_dRdata unchanged), drop o_mReq, go to DONE.
- DONE:
  - The owner's valid output is high for exactly this cycle.
  - Requests are ignored this cycle. The requester must drop or replace req before the next cycle.
  - Then go to IDLE.
- Latency: grant edge, then BUSY, then DONE.
  - Minimum is 3 cycles from IDLE-with-request to valid (i_mReady in the first BUSY cycle).
  - Back-to-back transactions therefore occupy 3 cycles each.
- Requests that rise while in BUSY or DONE are evaluated on the next IDLE cycle; nothing is queued.
- i_mReady outside BUSY is ignored.
- o_iData and o_dRdata hold their values until the next completion of the same port.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to BUSY and increments each BUSY cycle without i_mReady.
  - When the counter reaches TIMEOUT_CYCLES: drop o_mReq, go to DONE, pulse the owner's valid together with o_err for one cycle.
  - Return data: I-port 32'h00000013 (NOP), D-port 0.
- Undefined:
  - No counter; BUSY waits indefinitely.
  - o_err is tied 0.

Test Plan:
- Single fetch: i_iReq, addr 0x100; i_mReady in the 2nd BUSY cycle with rdata 0x00500093 -> o_mAddr = 0x100, o_mFunct3 = 3'b010, o_iData = 0x00500093, o_iValid one pulse 4 cycles after the request.
- Simultaneous i_iReq and i_dReq (load from 0x40) -> D is served first, then I. Each gets exactly one valid pulse; o_mReq never overlaps.
- i_dReq held continuously with i_iReq pending, MAX_D_STREAK = 4 -> grant order D, D, D, D, I, D; streak returns to 0 after the I grant.
- Store: i_dWrite = 1, addr 0x80, wdata 0xDEADBEEF, funct3 3'b010 -> o_mWrite = 1 with those values held through BUSY; o_dValid pulses; o_dRdata unchanged.
- i_reset_n pulled low in mid-BUSY -> o_mReq = 0 and state = IDLE immediately. After release, a pending i_dReq is granted cleanly.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, i_mReady never asserted on a fetch -> after 8 BUSY cycles: o_err and o_iValid pulse together, o_iData = 0x00000013.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// the fetch port (I) and the data port (D). D has priority; a streak limiter
// forces a pending fetch through after MAX_D_STREAK consecutive D grants.
// Optional feature macro: ARB_TIMEOUT_EN (memory-wait timeout with o_err pulse).
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_iReq,
  input  logic [31:0] i_iAddr,
  output logic [31:0] o_iData,
  output logic        o_iValid,
  input  logic        i_dReq,
  input  logic        i_dWrite,
  input  logic [31:0] i_dAddr,
  input  logic [31:0] i_dWdata,
  input  logic [2:0]  i_dFunct3,
  output logic [31:0] o_dRdata,
  output logic        o_dValid,
  output logic        o_mReq,
  output logic        o_mWrite,
  output logic [31:0] o_mAddr,
  output logic [31:0] o_mWdata,
  output logic [2:0]  o_mFunct3,
  input  logic        i_mReady,
  input  logic [31:0] i_mRdata,
  output logic        o_busy,
  output logic        o_err
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [DATA_W-1:0] NOP_INSN   = 32'h0000_0013;
  localparam logic [2:0]        FETCH_SIZE = 3'b010;

  // Reject configurations the streak limiter and timeout cannot honour.
  if (MAX_D_STREAK < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mem_port_arbiter: MAX_D_STREAK and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q,  state_n;
  logic [STREAK_W-1:0] streak_q, streak_n;
  logic                owner_d_q, owner_d_n;
  logic                m_req_n, m_write_n;
  logic [DATA_W-1:0]   m_addr_n, m_wdata_n;
  logic [2:0]          m_funct3_n;
  logic [DATA_W-1:0]   i_data_n, d_rdata_n;
  logic                i_valid_n, d_valid_n;
  logic                busy_n, err_n;
  logic                grant_d_c, grant_i_c;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_q, wait_n;
`endif

  // Arbitration: D wins unless fetch is pending and D has used up its streak.
  always_comb begin
    grant_d_c = i_dReq && (!i_iReq || (streak_q < STREAK_W'(MAX_D_STREAK)));
    grant_i_c = !grant_d_c && i_iReq;
  end

  // Next-state and next-output logic; every registered output has a default.
  always_comb begin
    state_n    = state_q;
    streak_n   = streak_q;
    owner_d_n  = owner_d_q;
    m_req_n    = o_mReq;
    m_write_n  = o_mWrite;
    m_addr_n   = o_mAddr;
    m_wdata_n  = o_mWdata;
    m_funct3_n = o_mFunct3;
    i_data_n   = o_iData;
    d_rdata_n  = o_dRdata;
    i_valid_n  = 1'b0;
    d_valid_n  = 1'b0;
    err_n      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wait_n     = wait_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_d_c) begin
          state_n    = BUSY;
          owner_d_n  = 1'b1;
          m_req_n    = 1'b1;
          m_write_n  = i_dWrite;
          m_addr_n   = i_dAddr;
          m_wdata_n  = i_dWdata;
          m_funct3_n = i_dFunct3;
          if (!i_iReq) begin
            streak_n = '0;
          end else if (streak_q < STREAK_W'(MAX_D_STREAK)) begin
            streak_n = streak_q + STREAK_W'(1);
          end
`ifdef ARB_TIMEOUT_EN
          wait_n = '0;
`endif
        end else if (grant_i_c) begin
          state_n    = BUSY;
          owner_d_n  = 1'b0;
          m_req_n    = 1'b1;
          m_write_n  = 1'b0;
          m_addr_n   = i_iAddr;
          m_wdata_n  = '0;
          m_funct3_n = FETCH_SIZE;
          streak_n   = '0;
`ifdef ARB_TIMEOUT_EN
          wait_n = '0;
`endif
        end
      end

      BUSY: begin
        if (i_mReady) begin
          state_n = DONE;
          m_req_n = 1'b0;
          if (owner_d_q) begin
            d_valid_n = 1'b1;
            if (!o_mWrite) begin
              d_rdata_n = i_mRdata;
            end
          end else begin
            i_valid_n = 1'b1;
            i_data_n  = i_mRdata;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          // Memory never answered: complete the owner with a safe value.
          state_n = DONE;
          m_req_n = 1'b0;
          err_n   = 1'b1;
          if (owner_d_q) begin
            d_valid_n = 1'b1;
            d_rdata_n = '0;
          end else begin
            i_valid_n = 1'b1;
            i_data_n  = NOP_INSN;
          end
        end else begin
          wait_n = wait_q + WAIT_W'(1);
        end
`endif
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      owner_d_q <= 1'b0;
      o_mReq    <= 1'b0;
      o_mWrite  <= 1'b0;
      o_mAddr   <= '0;
      o_mWdata  <= '0;
      o_mFunct3 <= '0;
      o_iData   <= NOP_INSN;
      o_dRdata  <= '0;
      o_iValid  <= 1'b0;
      o_dValid  <= 1'b0;
      o_busy    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      state_q   <= state_n;
      streak_q  <= streak_n;
      owner_d_q <= owner_d_n;
      o_mReq    <= m_req_n;
      o_mWrite  <= m_write_n;
      o_mAddr   <= m_addr_n;
      o_mWdata  <= m_wdata_n;
      o_mFunct3 <= m_funct3_n;
      o_iData   <= i_data_n;
      o_dRdata  <= d_rdata_n;
      o_iValid  <= i_valid_n;
      o_dValid  <= d_valid_n;
      o_busy    <= busy_n;
      o_err     <= err_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Memory-wait counter, cleared on every grant.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_n;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester and memory models run on the
// falling edge; expected memory transactions and port responses live in queues.
module tb_mem_port_arbiter;

  localparam int unsigned MAX_D_STREAK   = 4;
  localparam int unsigned TIMEOUT_CYCLES = 8;
  localparam int          SETTLE_LIMIT   = 2000;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_iReq, i_dReq, i_dWrite, i_mReady;
  logic [31:0] i_iAddr, i_dAddr, i_dWdata, i_mRdata;
  logic [2:0]  i_dFunct3;
  logic [31:0] o_iData, o_dRdata, o_mAddr, o_mWdata;
  logic        o_iValid, o_dValid, o_mReq, o_mWrite, o_busy, o_err;
  logic [2:0]  o_mFunct3;

  mem_port_arbiter #(.MAX_D_STREAK(MAX_D_STREAK), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_iReq(i_iReq), .i_iAddr(i_iAddr), .o_iData(o_iData), .o_iValid(o_iValid),
    .i_dReq(i_dReq), .i_dWrite(i_dWrite), .i_dAddr(i_dAddr), .i_dWdata(i_dWdata),
    .i_dFunct3(i_dFunct3), .o_dRdata(o_dRdata), .o_dValid(o_dValid),
    .o_mReq(o_mReq), .o_mWrite(o_mWrite), .o_mAddr(o_mAddr), .o_mWdata(o_mWdata),
    .o_mFunct3(o_mFunct3), .i_mReady(i_mReady), .i_mRdata(i_mRdata),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } txn_t;

  typedef struct {
    txn_t t;
    logic to;
    int   lat;
  } job_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } resp_t;

  txn_t  exp_m[$];
  job_t  job_i[$], job_d[$];
  resp_t exp_i[$], exp_d[$];

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          mem_lat = 1;
  int          wait_cnt = 0;
  int          i_start = 0, d_start = 0;
  logic        spurious = 1'b0;
  logic        i_active = 1'b0, d_active = 1'b0;
  logic        m_prev = 1'b0, prev_iv = 1'b0, prev_dv = 1'b0;
  logic [31:0] last_d = 32'h0;
  txn_t        snap;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return ~a ^ 32'h1234_5678;
  endfunction

  // Falling-edge model: check completions, play memory, issue queued requests.
  task automatic step();
    resp_t r;
    job_t  j;
    txn_t  e;
    if (o_iValid) begin
      check_eq("i_valid_width", 32'(prev_iv), 0);
      check_eq("mreq_in_done", 32'(o_mReq), 0);
      check_eq("busy_in_done", 32'(o_busy), 1);
      if (exp_i.size() == 0) check_eq("i_valid_unexpected", 32'(o_iValid), 0);
      else begin
        r = exp_i.pop_front();
        check_eq("i_data", o_iData, r.data);
        check_eq("i_err", 32'(o_err), 32'(r.err));
        if (r.lat != 0) check_eq("i_latency", 32'(cyc - i_start), 32'(r.lat));
      end
      i_iReq = 1'b0;
      i_active = 1'b0;
    end
    if (o_dValid) begin
      check_eq("d_valid_width", 32'(prev_dv), 0);
      check_eq("mreq_in_done", 32'(o_mReq), 0);
      check_eq("iv_dv_overlap", 32'(o_iValid), 0);
      if (exp_d.size() == 0) check_eq("d_valid_unexpected", 32'(o_dValid), 0);
      else begin
        r = exp_d.pop_front();
        check_eq("d_rdata", o_dRdata, r.data);
        check_eq("d_err", 32'(o_err), 32'(r.err));
        if (r.lat != 0) check_eq("d_latency", 32'(cyc - d_start), 32'(r.lat));
      end
      i_dReq = 1'b0;
      d_active = 1'b0;
    end
    if (o_err && !o_iValid && !o_dValid) check_eq("err_alone", 32'(o_err), 0);
    prev_iv = o_iValid;
    prev_dv = o_dValid;

    i_mReady = spurious;
    i_mRdata = spurious ? 32'hBAD0_BAD0 : 32'h0;
    if (o_mReq) begin
      if (!m_prev) begin
        snap = '{o_mWrite, o_mAddr, o_mWdata, o_mFunct3};
        wait_cnt = 0;
        if (exp_m.size() == 0) check_eq("mreq_unexpected", 32'(o_mReq), 0);
        else begin
          e = exp_m.pop_front();
          check_eq("m_write", 32'(o_mWrite), 32'(e.write));
          check_eq("m_addr", o_mAddr, e.addr);
          check_eq("m_funct3", 32'(o_mFunct3), 32'(e.funct3));
          if (e.write) check_eq("m_wdata", o_mWdata, e.wdata);
        end
      end else begin
        check_eq("m_addr_hold", o_mAddr, snap.addr);
        check_eq("m_write_hold", 32'(o_mWrite), 32'(snap.write));
        check_eq("m_wdata_hold", o_mWdata, snap.wdata);
        check_eq("m_funct3_hold", 32'(o_mFunct3), 32'(snap.funct3));
      end
      wait_cnt++;
      if (wait_cnt == mem_lat) begin
        i_mReady = 1'b1;
        i_mRdata = mem_data(o_mAddr);
      end
    end
    m_prev = o_mReq;

    if (!i_active && job_i.size() > 0) begin
      j = job_i.pop_front();
      i_iReq = 1'b1;
      i_iAddr = j.t.addr;
      i_active = 1'b1;
      i_start = cyc;
      exp_i.push_back('{j.to ? 32'h0000_0013 : mem_data(j.t.addr), j.to, j.lat});
    end
    if (!d_active && job_d.size() > 0) begin
      j = job_d.pop_front();
      i_dReq = 1'b1;
      i_dWrite = j.t.write;
      i_dAddr = j.t.addr;
      i_dWdata = j.t.wdata;
      i_dFunct3 = j.t.funct3;
      d_active = 1'b1;
      d_start = cyc;
      if (j.to) last_d = 32'h0;
      else if (!j.t.write) last_d = mem_data(j.t.addr);
      exp_d.push_back('{last_d, j.to, j.lat});
    end
  endtask

  task automatic fetch_job(input logic [31:0] a, input logic to, input int lat);
    job_i.push_back('{'{1'b0, a, 32'h0, 3'b010}, to, lat});
  endtask

  task automatic data_job(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input logic to, input int lat);
    job_d.push_back('{'{w, a, wd, f3}, to, lat});
  endtask

  task automatic exp_mem(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3);
    exp_m.push_back('{w, a, wd, f3});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((job_i.size() + job_d.size() + exp_i.size() + exp_d.size() + exp_m.size() != 0 ||
            i_active || d_active || o_busy) && n < SETTLE_LIMIT) begin
      @(negedge i_clk);
      n++;
    end
    check_eq({tag, "_settle"}, 32'(n >= SETTLE_LIMIT), 0);
    @(negedge i_clk);
  endtask

  initial begin
    int n;
    i_reset_n = 1'b0;
    {i_iReq, i_dReq, i_dWrite, i_mReady} = '0;
    {i_iAddr, i_dAddr, i_dWdata, i_mRdata} = '0;
    i_dFunct3 = '0;
    fork
      forever begin
        @(negedge i_clk);
        step();
      end
    join_none

    #12;
    check_eq("rst_iData", o_iData, 32'h0000_0013);
    check_eq("rst_dRdata", o_dRdata, 0);
    check_eq("rst_valids", {30'h0, o_iValid, o_dValid}, 0);
    check_eq("rst_mReq", 32'(o_mReq), 0);
    check_eq("rst_mWrite", 32'(o_mWrite), 0);
    check_eq("rst_mAddr", o_mAddr, 0);
    check_eq("rst_mWdata", o_mWdata, 0);
    check_eq("rst_mFunct3", 32'(o_mFunct3), 0);
    check_eq("rst_busy", 32'(o_busy), 0);
    check_eq("rst_err", 32'(o_err), 0);
    #10 i_reset_n = 1'b1;
    @(negedge i_clk);

    // Single fetch, memory answers in the second BUSY cycle.
    mem_lat = 2;
    exp_mem(1'b0, 32'h100, 32'h0, 3'b010);
    fetch_job(32'h100, 1'b0, 3);
    wait_idle("single_fetch");

    // Simultaneous requests: D first, then I.
    @(posedge i_clk); #1;
    mem_lat = 1;
    exp_mem(1'b0, 32'h40, 32'h0, 3'b010);
    exp_mem(1'b0, 32'h104, 32'h0, 3'b010);
    data_job(1'b0, 32'h40, 32'h0, 3'b010, 1'b0, 2);
    fetch_job(32'h104, 1'b0, 0);
    wait_idle("simultaneous");

    // Continuous D with fetch pending: D D D D I D D D D I.
    @(posedge i_clk); #1;
    for (int k = 0; k < 8; k++) begin
      data_job(1'b0, 32'h200 + 32'(4 * k), 32'h0, 3'(k), 1'b0, 0);
    end
    fetch_job(32'h300, 1'b0, 0);
    fetch_job(32'h304, 1'b0, 0);
    for (int k = 0; k < 4; k++) exp_mem(1'b0, 32'h200 + 32'(4 * k), 32'h0, 3'(k));
    exp_mem(1'b0, 32'h300, 32'h0, 3'b010);
    for (int k = 4; k < 8; k++) exp_mem(1'b0, 32'h200 + 32'(4 * k), 32'h0, 3'(k));
    exp_mem(1'b0, 32'h304, 32'h0, 3'b010);
    wait_idle("streak");

    // Store: held through a longer BUSY, load data register untouched.
    @(posedge i_clk); #1;
    mem_lat = 3;
    exp_mem(1'b1, 32'h80, 32'hDEAD_BEEF, 3'b010);
    data_job(1'b1, 32'h80, 32'hDEAD_BEEF, 3'b010, 1'b0, 4);
    wait_idle("store");

    // Memory ready while idle is ignored.
    spurious = 1'b1;
    repeat (4) @(negedge i_clk);
    check_eq("spurious_busy", 32'(o_busy), 0);
    check_eq("spurious_mreq", 32'(o_mReq), 0);
    spurious = 1'b0;
    @(negedge i_clk);

    // Reset in the middle of BUSY; the held D request is regranted afterwards.
    @(posedge i_clk); #1;
    mem_lat = 100;
    exp_mem(1'b0, 32'hC0, 32'h0, 3'b010);
    exp_mem(1'b0, 32'hC0, 32'h0, 3'b010);
    data_job(1'b0, 32'hC0, 32'h0, 3'b010, 1'b0, 0);
    n = 0;
    while (!o_mReq && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    check_eq("rst_wait_mreq", 32'(o_mReq), 1);
    @(posedge i_clk); #2;
    i_reset_n = 1'b0;
    #1;
    check_eq("midrst_mReq", 32'(o_mReq), 0);
    check_eq("midrst_busy", 32'(o_busy), 0);
    check_eq("midrst_dValid", 32'(o_dValid), 0);
    check_eq("midrst_iData", o_iData, 32'h0000_0013);
    mem_lat = 1;
    @(posedge i_clk); #2;
    i_reset_n = 1'b1;
    wait_idle("after_reset");

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: fetch returns NOP, load returns zero, both with o_err.
    @(posedge i_clk); #1;
    mem_lat = 1000;
    exp_mem(1'b0, 32'h180, 32'h0, 3'b010);
    fetch_job(32'h180, 1'b1, TIMEOUT_CYCLES + 1);
    wait_idle("timeout_fetch");
    @(posedge i_clk); #1;
    exp_mem(1'b0, 32'h1C0, 32'h0, 3'b001);
    data_job(1'b0, 32'h1C0, 32'h0, 3'b001, 1'b1, TIMEOUT_CYCLES + 1);
    wait_idle("timeout_load");
    mem_lat = 1;
`endif

    check_eq("exp_m_left", 32'(exp_m.size()), 0);
    check_eq("exp_i_left", 32'(exp_i.size()), 0);
    check_eq("exp_d_left", 32'(exp_d.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
